// File: rtl/beep_decoder.sv
//------------------------------------------------------------------------------
// beep_decoder : decodes tone bursts, inter-burst gaps and burst groups from a
//                buzzer drive line (low phase = tone drive, idle = held high).
// Revision     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module beep_decoder #(
  parameter int CNT_W     = 28,
  parameter int PER_W     = 16,
  parameter int HOLD_CYC  = 20000,
  parameter int MIN_BURST = 1024,
  parameter int GROUP_GAP = 2**26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             beep_in,
  output logic             tone_on,
  output logic [PER_W-1:0] tone_period,
  output logic             burst_valid,
  output logic [CNT_W-1:0] burst_len,
  output logic [CNT_W-1:0] gap_len,
  output logic             group_valid,
  output logic [7:0]       group_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GROUP_LAST = CNT_W'(GROUP_GAP - 1);
  localparam logic [CNT_W-1:0] MIN_LEN    = CNT_W'(MIN_BURST);
  localparam logic [CNT_W-1:0] PER_SAT    = CNT_W'((64'd1 << PER_W) - 64'd1);
  localparam logic [PER_W-1:0] PER_MAX    = {PER_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state;
  logic             sync1, sync2, prev;
  logic             fall;
  logic [CNT_W-1:0] since_edge;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] last_edge;
  logic [CNT_W-1:0] gap_timer;
  logic [CNT_W-1:0] pend_gap;
  logic [7:0]       grp_int;
  logic             from_gap;
  logic [PER_W-1:0] period_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == CNT_MAX) ? x : x + CNT_W'(1);
  endfunction

  assign fall    = prev & ~sync2;
  assign tone_on = (state == TONE);

  // All stored lengths are registered one cycle late, so each capture adds one.
  assign period_next = (since_edge >= PER_SAT) ? PER_MAX
                                               : since_edge[PER_W-1:0] + PER_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      prev        <= 1'b1;
      since_edge  <= '0;
      burst_cnt   <= '0;
      last_edge   <= '0;
      gap_timer   <= '0;
      pend_gap    <= '0;
      grp_int     <= '0;
      from_gap    <= 1'b0;
      tone_period <= '0;
      burst_valid <= 1'b0;
      burst_len   <= '0;
      gap_len     <= '0;
      group_valid <= 1'b0;
      group_cnt   <= '0;
    end else begin
      sync1       <= beep_in;
      sync2       <= sync1;
      prev        <= sync2;
      burst_valid <= 1'b0;
      group_valid <= 1'b0;
      since_edge  <= fall ? '0 : sat_inc(since_edge);
      burst_cnt   <= sat_inc(burst_cnt);
      gap_timer   <= sat_inc(gap_timer);

      case (state)
        IDLE: begin
          if (fall) begin
            state     <= TONE;
            burst_cnt <= '0;
            last_edge <= '0;
            pend_gap  <= '0;
            grp_int   <= '0;
            from_gap  <= 1'b0;
          end
        end
        TONE: begin
          if (fall) begin
            tone_period <= period_next;
            last_edge   <= sat_inc(burst_cnt);
          end else if (since_edge == HOLD_LAST) begin
            if (last_edge >= MIN_LEN) begin
              burst_valid <= 1'b1;
              burst_len   <= last_edge;
              gap_len     <= pend_gap;
              grp_int     <= (grp_int == 8'hFF) ? grp_int : grp_int + 8'd1;
              gap_timer   <= sat_inc(since_edge);
              state       <= GAP;
            end else begin
              // Glitch: drop it and keep the gap timer running from the last good edge.
              state <= from_gap ? GAP : IDLE;
            end
          end
        end
        GAP: begin
          if (fall) begin
            state     <= TONE;
            burst_cnt <= '0;
            last_edge <= '0;
            pend_gap  <= sat_inc(gap_timer);
            from_gap  <= 1'b1;
          end else if (gap_timer >= GROUP_LAST) begin
            // >= so a glitch straddling the group timeout still closes the group.
            group_valid <= 1'b1;
            group_cnt   <= grp_int;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
